// File: rtl/mul_4x3_seq_ctrl.sv
// ============================================================================
// Module  : mul_4x3_seq_ctrl
// Brief   : Sequential shift-and-add multiplier with valid/ready handshakes.
//           Optional early termination with `define MUL_SKIP_ZERO_EN.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module mul_4x3_seq_ctrl #(
   parameter int A_WIDTH = 3,
   parameter int B_WIDTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [A_WIDTH-1:0]         a,
   input  logic [B_WIDTH-1:0]         b,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [A_WIDTH+B_WIDTH-1:0] product,
   output logic                       busy
);

   localparam int P_WIDTH = A_WIDTH + B_WIDTH;
   localparam int CNT_W   = $clog2(A_WIDTH + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(A_WIDTH - 1);

   logic [1:0]         state_q,   state_d;
   logic [P_WIDTH-1:0] acc_q,     acc_d;
   logic [P_WIDTH-1:0] mcand_q,   mcand_d;
   logic [A_WIDTH-1:0] mplier_q,  mplier_d;
   logic [CNT_W-1:0]   cnt_q,     cnt_d;
   logic [P_WIDTH-1:0] product_q, product_d;

   logic               w_accept;
   logic               w_last;
   logic [P_WIDTH-1:0] w_sum;

   assign w_accept = (state_q == S_IDLE) && in_valid;
   assign w_sum    = acc_q + mcand_q;

`ifdef MUL_SKIP_ZERO_EN
   // Stop as soon as no set multiplier bits remain for later steps.
   assign w_last = (cnt_q == C_LAST_CNT) || ((mplier_q >> 1) == '0);
`else
   assign w_last = (cnt_q == C_LAST_CNT);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
`ifdef MUL_SKIP_ZERO_EN
               state_d = (a == '0) ? S_DONE : S_RUN;
`else
               state_d = S_RUN;
`endif
            end
         end
         S_RUN:   if (w_last)    state_d = S_DONE;
         S_DONE:  if (out_ready) state_d = S_IDLE;
         default:                state_d = S_IDLE;
      endcase
   end

   always_comb begin
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      if (w_accept) begin
         acc_d    = '0;
         mcand_d  = {{A_WIDTH{1'b0}}, b};
         mplier_d = a;
         cnt_d    = '0;
`ifdef MUL_SKIP_ZERO_EN
         if (a == '0) product_d = '0;
`endif
      end else if (state_q == S_RUN) begin
         acc_d    = mplier_q[0] ? w_sum : acc_q;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + 1'b1;
         if (w_last) product_d = acc_d;
      end
   end

   always_comb begin
      in_ready  = (state_q == S_IDLE);
      out_valid = (state_q == S_DONE);
      busy      = (state_q == S_RUN) || (state_q == S_DONE);
   end

   assign product = product_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_4x3_seq_ctrl.sv
// ============================================================================
// Module  : tb_mul_4x3_seq_ctrl
// Brief   : Randomised self-checking bench; reference is plain a*b arithmetic.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mul_4x3_seq_ctrl;

   localparam int A_WIDTH = 3;
   localparam int B_WIDTH = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] a;
   logic [3:0] b;
   logic       out_valid;
   logic       out_ready;
   logic [6:0] product;
   logic       busy;

   int checks = 0;
   int errors = 0;

   mul_4x3_seq_ctrl #(.A_WIDTH(A_WIDTH), .B_WIDTH(B_WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic int exp_lat(input logic [2:0] x);
      int m;
`ifdef MUL_SKIP_ZERO_EN
      m = 0;
      for (int i = 0; i < A_WIDTH; i++) if (x[i]) m = i + 1;
`else
      m = A_WIDTH;
`endif
      return m;
   endfunction

   // Issues one job from a negedge; returns at the first negedge with out_valid.
   task automatic send_and_wait(input logic [2:0] ta, input logic [3:0] tbv,
                                output int lat, output bit to);
      int guard = 0;
      to  = 1'b0;
      lat = 0;
      while (!in_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         to = 1'b1;
         return;
      end
      a = ta; b = tbv; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      a = 3'($urandom); b = 4'($urandom);
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (!out_valid) to = 1'b1;
   endtask

   task automatic take_output();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      #3;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== 7'd0) begin
         errors++;
         $display("FAIL reset: in_ready=%b out_valid=%b busy=%b product=%0d, required 1 0 0 0",
                  in_ready, out_valid, busy, product);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [2:0] ta[2] = '{3'd7, 3'd0};
      logic [3:0] tb[2] = '{4'd15, 4'd9};
      int lat; bit to;
      for (int i = 0; i < 2; i++) begin
         send_and_wait(ta[i], tb[i], lat, to);
         checks++;
         if (to || product !== 7'(ta[i] * tb[i])) begin
            errors++;
            $display("FAIL basic_product a=%0d b=%0d: got %0d timeout=%0d, required %0d",
                     ta[i], tb[i], product, to, ta[i] * tb[i]);
         end
         checks++;
         if (lat != exp_lat(ta[i])) begin
            errors++;
            $display("FAIL basic_latency a=%0d: got %0d edges, required %0d", ta[i], lat, exp_lat(ta[i]));
         end
         take_output();
      end
   endtask

   task automatic test_stall();
      int lat; bit to;
      send_and_wait(3'd5, 4'd9, lat, to);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (to || product !== 7'd45 || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stall cycle %0d: product=%0d out_valid=%b in_ready=%b busy=%b, required 45 1 0 1",
                     i, product, out_valid, in_ready, busy);
         end
         @(negedge clk);
      end
      take_output();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 7'd45) begin
         errors++;
         $display("FAIL stall_release: in_ready=%b out_valid=%b product=%0d, required 1 0 45",
                  in_ready, out_valid, product);
      end
   endtask

   task automatic test_reset_midop();
      int lat; bit to;
      a = 3'd3; b = 4'd3; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== 7'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_midop: out_valid=%b in_ready=%b product=%0d busy=%b, required 0 1 0 0",
                  out_valid, in_ready, product, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_and_wait(3'd2, 4'd6, lat, to);
      checks++;
      if (to || product !== 7'd12) begin
         errors++;
         $display("FAIL reset_recover: got %0d timeout=%0d, required 12", product, to);
      end
      take_output();
   endtask

   task automatic test_back_to_back();
      logic [2:0] oa[3] = '{3'd3, 3'd6, 3'd1};
      logic [3:0] ob[3] = '{4'd4, 4'd11, 4'd15};
      logic [6:0] got[$];
      int rdy_cyc[$];
      int idx = 0;
      int cyc = 0;
      bit prev_rdy = 1'b0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      while ((idx < 3 || got.size() < 3) && cyc < 80) begin
         if (out_valid) got.push_back(product);
         if (in_ready && idx < 3) begin
            checks++;
            if (prev_rdy) begin
               errors++;
               $display("FAIL b2b_ready_pulse: in_ready high 2 cycles at cycle %0d, required 1", cyc);
            end
            a = oa[idx]; b = ob[idx];
            rdy_cyc.push_back(cyc);
            idx++;
         end else if (in_ready) begin
            in_valid = 1'b0;
         end else begin
            a = 3'($urandom); b = 4'($urandom);
         end
         prev_rdy = in_ready;
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      checks++;
      if (got.size() != 3) begin
         errors++;
         $display("FAIL b2b_count: got %0d products, required 3", got.size());
      end
      for (int i = 0; i < 3 && i < got.size(); i++) begin
         checks++;
         if (got[i] !== 7'(oa[i] * ob[i])) begin
            errors++;
            $display("FAIL b2b_product[%0d]: got %0d, required %0d", i, got[i], oa[i] * ob[i]);
         end
      end
`ifndef MUL_SKIP_ZERO_EN
      for (int i = 1; i < rdy_cyc.size(); i++) begin
         checks++;
         if (rdy_cyc[i] - rdy_cyc[i-1] != A_WIDTH + 2) begin
            errors++;
            $display("FAIL b2b_throughput: spacing %0d, required %0d", rdy_cyc[i] - rdy_cyc[i-1], A_WIDTH + 2);
         end
      end
`endif
      @(negedge clk);
   endtask

   task automatic test_random();
      int lat; bit to;
      logic [2:0] ra; logic [3:0] rb;
      for (int n = 0; n < 25; n++) begin
         ra = 3'($urandom); rb = 4'($urandom);
         send_and_wait(ra, rb, lat, to);
         repeat ($urandom_range(0, 3)) begin
            checks++;
            if (out_valid !== 1'b1 || product !== 7'(ra * rb)) begin
               errors++;
               $display("FAIL random_hold a=%0d b=%0d: out_valid=%b product=%0d, required 1 %0d",
                        ra, rb, out_valid, product, ra * rb);
            end
            @(negedge clk);
         end
         checks++;
         if (to || product !== 7'(ra * rb) || lat != exp_lat(ra)) begin
            errors++;
            $display("FAIL random a=%0d b=%0d: product=%0d lat=%0d timeout=%0d, required %0d lat %0d",
                     ra, rb, product, lat, to, ra * rb, exp_lat(ra));
         end
         take_output();
      end
   endtask

   task automatic test_sweep();
      int lat; bit to;
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 16; j++) begin
            send_and_wait(3'(i), 4'(j), lat, to);
            checks++;
            if (to || product !== 7'(i * j) || lat != exp_lat(3'(i))) begin
               errors++;
               $display("FAIL sweep a=%0d b=%0d: product=%0d lat=%0d timeout=%0d, required %0d lat %0d",
                        i, j, product, lat, to, i * j, exp_lat(3'(i)));
            end
            take_output();
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_reset_midop();
      test_back_to_back();
      test_random();
      test_sweep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
